// File: rtl/xb_regfile_pkg.sv
// Shared register-file constants and helpers, imported by the decoder and by xb_regfile.
// Optional build macro XB_BYPASS_EN (see xb_regfile.sv).
package xb_regfile_pkg;

  localparam int XB_DATA_W = 16;
  localparam int XB_NREG   = 16;
  localparam int XB_ADDR_W = 4;

  // Bit positions inside the registered per-CU write-enable vector
  localparam int XB_CU_NUM = 3;
  localparam int XB_CU_ALU = 0;
  localparam int XB_CU_MUL = 1;
  localparam int XB_CU_SHF = 2;

  typedef logic [XB_CU_NUM-1:0] cu_en_t;

  function automatic logic multi_hot(input cu_en_t en);
    return (en & (en - cu_en_t'(1))) != cu_en_t'(0);
  endfunction

endpackage

// File: rtl/xb_regfile_array.sv
// NREG x DATA_W storage: one synchronous write port, two asynchronous read ports, async clear.
module xb_regfile_array
  import xb_regfile_pkg::*;
#(
  parameter int DATA_W = XB_DATA_W,
  parameter int NREG   = XB_NREG,
  parameter int ADDR_W = XB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/xb_regfile.sv
// Crossbar register file: registered operand capture, CU write-back and a DM write port on a req/ack handshake.
// Build macro XB_BYPASS_EN forwards same-edge write data into the captured operands.
module xb_regfile
  import xb_regfile_pkg::*;
#(
  parameter int DATA_W = XB_DATA_W,
  parameter int NREG   = XB_NREG,
  parameter int ADDR_W = XB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    ps_xb_rd_a0,
  input  logic [ADDR_W-1:0]    ps_xb_raddy,
  input  logic [ADDR_W-1:0]    ps_xb_wrt_a,
  input  logic [XB_CU_NUM-1:0] ps_xb_w_cuEn,
  input  logic [DATA_W-1:0]    alu_res,
  input  logic [DATA_W-1:0]    mul_res,
  input  logic [DATA_W-1:0]    shf_res,
  input  logic                 dm_wr_req,
  input  logic [ADDR_W-1:0]    dm_wr_a,
  input  logic [DATA_W-1:0]    dm_wr_d,
  output logic                 dm_wr_ack,
  output logic [DATA_W-1:0]    xb_rx,
  output logic [DATA_W-1:0]    xb_ry,
  output logic                 xb_wr_coll
);

  logic [ADDR_W-1:0] wa_q;
  logic              cu_we;
  logic [DATA_W-1:0] cu_res;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] ry_next;

  assign cu_we = |ps_xb_w_cuEn;

  // Fixed priority when several CUs claim the write slot: ALU, then MUL, then SHF
  always_comb begin
    cu_res = shf_res;
    if (ps_xb_w_cuEn[XB_CU_ALU])      cu_res = alu_res;
    else if (ps_xb_w_cuEn[XB_CU_MUL]) cu_res = mul_res;
  end

  // The DM port only gets the single write port on cycles the CUs leave idle
  assign dm_wr_ack = dm_wr_req & ~cu_we & ~rst;

  assign we = cu_we | dm_wr_ack;
  assign wa = cu_we ? wa_q : dm_wr_a;
  assign wd = cu_we ? cu_res : dm_wr_d;

  xb_regfile_array #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra0 (ps_xb_rd_a0),
    .ra1 (ps_xb_raddy),
    .rd0 (rd0),
    .rd1 (rd1)
  );

  always_comb begin
    rx_next = rd0;
    ry_next = rd1;
`ifdef XB_BYPASS_EN
    if (cu_we && ps_xb_rd_a0 == wa_q)               rx_next = cu_res;
    else if (dm_wr_ack && ps_xb_rd_a0 == dm_wr_a)   rx_next = dm_wr_d;
    if (cu_we && ps_xb_raddy == wa_q)               ry_next = cu_res;
    else if (dm_wr_ack && ps_xb_raddy == dm_wr_a)   ry_next = dm_wr_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xb_rx      <= '0;
      xb_ry      <= '0;
      wa_q       <= '0;
      xb_wr_coll <= 1'b0;
    end else begin
      xb_rx <= rx_next;
      xb_ry <= ry_next;
      wa_q  <= ps_xb_wrt_a;
      if (multi_hot(ps_xb_w_cuEn)) xb_wr_coll <= 1'b1;
    end
  end

endmodule
